// File: rtl/fpu_issue_ctrl_if.sv
// rtl/fpu_issue_ctrl_if.sv - request, unit and writeback signals of the fixed-point issue sequencer
// Signals:
//   req_valid/req_ready/req_op/req_op1/req_op2/req_rd  execute-stage request handshake
//   fu_operand_1/fu_operand_2/fu_operation             held inputs to the fixed-point unit
//   fu_result/fu_ready                                 outputs of the fixed-point unit
//   wb_valid/wb_ready/wb_rd/wb_data/wb_err             register-file writeback handshake
//   busy                                               sequencer not idle
// Modports: slave = sequencer view, master = surrounding pipeline/unit view.
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`define FPU_SUB  2'b01
`define FPU_MUL  2'b10
`define FPU_SQRT 2'b11
`endif

interface fpu_issue_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_op1;
  logic [WIDTH-1:0] req_op2;
  logic [4:0]       req_rd;
  logic [WIDTH-1:0] fu_operand_1;
  logic [WIDTH-1:0] fu_operand_2;
  logic [1:0]       fu_operation;
  logic [WIDTH-1:0] fu_result;
  logic             fu_ready;
  logic             wb_valid;
  logic             wb_ready;
  logic [4:0]       wb_rd;
  logic [WIDTH-1:0] wb_data;
  logic             wb_err;
  logic             busy;

  modport slave (
    input  req_valid, req_op, req_op1, req_op2, req_rd, fu_result, fu_ready, wb_ready,
    output req_ready, fu_operand_1, fu_operand_2, fu_operation,
           wb_valid, wb_rd, wb_data, wb_err, busy
  );

  modport master (
    output req_valid, req_op, req_op1, req_op2, req_rd, fu_result, fu_ready, wb_ready,
    input  req_ready, fu_operand_1, fu_operand_2, fu_operation,
           wb_valid, wb_rd, wb_data, wb_err, busy
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// rtl/fpu_issue_ctrl.sv - one-at-a-time issue sequencer and writeback buffer for the fixed-point unit
// Ports:
//   clk    clock
//   reset  asynchronous, active-high; abandons any in-flight operation
//   bus    fpu_issue_ctrl_if.slave (request in, unit operands out / result in, writeback out, busy)
// Parameters: WIDTH (must match the interface), MIN_WAIT (stale-ready blanking for MUL/SQRT),
//   TIMEOUT (WAIT cycles before an error writeback).
// Optional macro FPU_TIMEOUT_EN: WAIT gives up after TIMEOUT cycles with wb_err=1, wb_data=0.
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`define FPU_SUB  2'b01
`define FPU_MUL  2'b10
`define FPU_SQRT 2'b11
`endif

module fpu_issue_ctrl #(
  parameter int WIDTH    = 32,
  parameter int MIN_WAIT = 2,
  parameter int TIMEOUT  = 64
) (
  input logic             clk,
  input logic             reset,
  fpu_issue_ctrl_if.slave bus
);
  localparam int CNT_LIM = (TIMEOUT > MIN_WAIT) ? TIMEOUT : MIN_WAIT;
  localparam int CNT_W   = $clog2(CNT_LIM + 2);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] MIN_WAIT_C = CNT_W'(MIN_WAIT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] data_q;
  logic [1:0]       op_q;
  logic [4:0]       rd_q;
  logic [CNT_W-1:0] cnt;
  logic             long_op;
  logic             ready_ok;
  logic             accept;
  logic             capture;
  logic             req_ready_o;
  logic             busy_o;
  logic             wb_valid_o;

  // MUL/SQRT may still see the previous op's ready for a few cycles, so it is blanked
  // until the wait counter reaches MIN_WAIT; ADD/SUB results are trusted immediately.
  assign long_op  = (op_q == `FPU_MUL) || (op_q == `FPU_SQRT);
  assign ready_ok = bus.fu_ready && (!long_op || (cnt >= MIN_WAIT_C));
  assign accept   = (state == IDLE) && bus.req_valid;
  assign capture  = ((state == ISSUE) && !long_op && bus.fu_ready) ||
                    ((state == WAIT) && ready_ok);

`ifdef FPU_TIMEOUT_EN
  logic timeout_hit;
  logic err_q;
  // Fires on the last WAIT cycle; an accepted ready in that same cycle takes priority.
  assign timeout_hit = (state == WAIT) && !ready_ok && (cnt == CNT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (accept) state_next = ISSUE;
      ISSUE: state_next = capture ? WB : WAIT;
      WAIT: begin
        if (capture) state_next = WB;
`ifdef FPU_TIMEOUT_EN
        else if (timeout_hit) state_next = WB;
`endif
      end
      WB:    if (bus.wb_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 1'b0;
    busy_o      = 1'b1;
    wb_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      WB:      wb_valid_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= `FPU_ADD;
      op1_q  <= '0;
      op2_q  <= '0;
      rd_q   <= '0;
      data_q <= '0;
      cnt    <= '0;
    end else begin
      if (accept) begin
        op_q  <= bus.req_op;
        op1_q <= bus.req_op1;
        op2_q <= bus.req_op2;
        rd_q  <= bus.req_rd;
      end
      // Saturates so a very long wait can never wrap back into the blanking window.
      if (state == ISSUE)
        cnt <= '0;
      else if ((state == WAIT) && (cnt != CNT_MAX))
        cnt <= cnt + 1'b1;
      if (capture)
        data_q <= bus.fu_result;
`ifdef FPU_TIMEOUT_EN
      else if (timeout_hit)
        data_q <= '0;
`endif
    end
  end

`ifdef FPU_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            err_q <= 1'b0;
    else if (capture)     err_q <= 1'b0;
    else if (timeout_hit) err_q <= 1'b1;
  end
  assign bus.wb_err = err_q;
`else
  assign bus.wb_err = 1'b0;
`endif

  assign bus.req_ready    = req_ready_o;
  assign bus.busy         = busy_o;
  assign bus.wb_valid     = wb_valid_o;
  assign bus.wb_rd        = rd_q;
  assign bus.wb_data      = data_q;
  assign bus.fu_operand_1 = op1_q;
  assign bus.fu_operand_2 = op2_q;
  assign bus.fu_operation = op_q;
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb/tb_fpu_issue_ctrl.sv - directed self-checking bench for fpu_issue_ctrl
`ifndef FPU_ADD
`define FPU_ADD  2'b00
`define FPU_SUB  2'b01
`define FPU_MUL  2'b10
`define FPU_SQRT 2'b11
`endif

module tb_fpu_issue_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  fpu_issue_ctrl_if #(.WIDTH(32)) bus ();

  fpu_issue_ctrl #(.WIDTH(32), .MIN_WAIT(2), .TIMEOUT(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.req_op    = op;
    bus.req_op1   = a;
    bus.req_op2   = b;
    bus.req_rd    = rd;
    bus.req_valid = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %0h exp 1", bus.req_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid got %0h exp 0", bus.wb_valid); end
    checks++; if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL rst_wb_err got %0h exp 0", bus.wb_err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", bus.busy); end
    checks++; if (bus.wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wb_rd got %0h exp 0", bus.wb_rd); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data got %h exp 0", bus.wb_data); end
    checks++; if (bus.fu_operand_1 !== 32'h0) begin errors++; $display("FAIL rst_op1 got %h exp 0", bus.fu_operand_1); end
    checks++; if (bus.fu_operand_2 !== 32'h0) begin errors++; $display("FAIL rst_op2 got %h exp 0", bus.fu_operand_2); end
    checks++; if (bus.fu_operation !== `FPU_ADD) begin errors++; $display("FAIL rst_operation got %0h exp %0h", bus.fu_operation, `FPU_ADD); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_add();
    bus.fu_ready  = 1'b1;
    bus.fu_result = 32'h0000_1000;
    bus.wb_ready  = 1'b1;
    issue(`FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd5);
    tick();  // cycle 1: ISSUE
    bus.req_valid = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL add_busy got %0h exp 1", bus.busy); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL add_req_ready got %0h exp 0", bus.req_ready); end
    checks++; if (bus.fu_operand_1 !== 32'h0000_0C00) begin errors++; $display("FAIL add_op1 got %h exp 00000c00", bus.fu_operand_1); end
    checks++; if (bus.fu_operand_2 !== 32'h0000_0400) begin errors++; $display("FAIL add_op2 got %h exp 00000400", bus.fu_operand_2); end
    checks++; if (bus.fu_operation !== `FPU_ADD) begin errors++; $display("FAIL add_operation got %0h exp %0h", bus.fu_operation, `FPU_ADD); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_valid_c1 got %0h exp 0", bus.wb_valid); end
    tick();  // cycle 2: WB
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid_c2 got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'h0000_1000) begin errors++; $display("FAIL add_wb_data got %h exp 00001000", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd5) begin errors++; $display("FAIL add_wb_rd got %0d exp 5", bus.wb_rd); end
    checks++; if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL add_wb_err got %0h exp 0", bus.wb_err); end
    tick();  // cycle 3: back in IDLE
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL add_wb_valid_c3 got %0h exp 0", bus.wb_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL add_req_ready_c3 got %0h exp 1", bus.req_ready); end
  endtask

  task automatic test_mul_stale();
    bus.fu_ready  = 1'b1;
    bus.fu_result = 32'hDEAD_BEEF;
    bus.wb_ready  = 1'b1;
    issue(`FPU_MUL, 32'h0000_0800, 32'h0000_0800, 5'd7);
    for (int c = 1; c <= 6; c++) begin
      tick();
      bus.req_valid = 1'b0;
      // stale ready through cycle 3, unit busy on 4-5, real result on 6
      bus.fu_ready  = (c <= 3) || (c == 6);
      bus.fu_result = (c == 6) ? 32'h0000_1000 : 32'hDEAD_BEEF;
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mul_wb_valid_c%0d got %0h exp 0", c, bus.wb_valid); end
      checks++; if (bus.fu_operation !== `FPU_MUL) begin errors++; $display("FAIL mul_operation_c%0d got %0h exp %0h", c, bus.fu_operation, `FPU_MUL); end
    end
    tick();  // cycle 7
    bus.fu_ready = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL mul_wb_valid_c7 got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'h0000_1000) begin errors++; $display("FAIL mul_wb_data got %h exp 00001000", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd7) begin errors++; $display("FAIL mul_wb_rd got %0d exp 7", bus.wb_rd); end
    checks++; if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL mul_wb_err got %0h exp 0", bus.wb_err); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL mul_wb_valid_c8 got %0h exp 0", bus.wb_valid); end
  endtask

  task automatic test_min_wait_edge();
    bus.fu_ready  = 1'b0;
    bus.fu_result = 32'h0000_0800;
    bus.wb_ready  = 1'b1;
    issue(`FPU_SQRT, 32'h0000_1000, 32'h0, 5'd3);
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.req_valid = 1'b0;
      bus.fu_ready  = (c == 4);  // counter equals MIN_WAIT on cycle 4
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL edge_wb_valid_c%0d got %0h exp 0", c, bus.wb_valid); end
    end
    tick();  // cycle 5
    bus.fu_ready = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL edge_wb_valid_c5 got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'h0000_0800) begin errors++; $display("FAIL edge_wb_data got %h exp 00000800", bus.wb_data); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.fu_ready  = 1'b1;
    bus.fu_result = 32'hFFFF_F800;
    bus.wb_ready  = 1'b0;
    issue(`FPU_SUB, 32'h0000_0400, 32'h0000_0C00, 5'd9);
    tick();  // cycle 1: a second request is presented while busy
    issue(`FPU_ADD, 32'h0000_0100, 32'h0000_0200, 5'd2);
    for (int c = 2; c <= 6; c++) begin
      tick();
      checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL bp_wb_valid_c%0d got %0h exp 1", c, bus.wb_valid); end
      checks++; if (bus.wb_data !== 32'hFFFF_F800) begin errors++; $display("FAIL bp_wb_data_c%0d got %h exp fffff800", c, bus.wb_data); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready_c%0d got %0h exp 0", c, bus.req_ready); end
    end
    tick();  // cycle 7: consumer accepts
    bus.wb_ready = 1'b1;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL bp_wb_valid_c7 got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_rd !== 5'd9) begin errors++; $display("FAIL bp_wb_rd got %0d exp 9", bus.wb_rd); end
    tick();  // cycle 8: IDLE, pending request accepted now
    bus.fu_result = 32'h0000_0300;
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL bp_wb_valid_c8 got %0h exp 0", bus.wb_valid); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL bp_req_ready_c8 got %0h exp 1", bus.req_ready); end
    checks++; if (bus.fu_operand_1 !== 32'h0000_0400) begin errors++; $display("FAIL bp_op1_c8 got %h exp 00000400", bus.fu_operand_1); end
    tick();  // cycle 9: ISSUE of second request
    bus.req_valid = 1'b0;
    checks++; if (bus.fu_operand_1 !== 32'h0000_0100) begin errors++; $display("FAIL bp_op1_c9 got %h exp 00000100", bus.fu_operand_1); end
    checks++; if (bus.fu_operation !== `FPU_ADD) begin errors++; $display("FAIL bp_operation_c9 got %0h exp %0h", bus.fu_operation, `FPU_ADD); end
    tick();  // cycle 10
    checks++; if (bus.wb_data !== 32'h0000_0300) begin errors++; $display("FAIL bp_wb_data_c10 got %h exp 00000300", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd2) begin errors++; $display("FAIL bp_wb_rd_c10 got %0d exp 2", bus.wb_rd); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    bus.fu_ready = 1'b0;
    bus.wb_ready = 1'b1;
    issue(`FPU_SQRT, 32'h0000_1000, 32'h0, 5'd4);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmw_busy got %0h exp 0", bus.busy); end
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rmw_req_ready got %0h exp 1", bus.req_ready); end
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rmw_wb_valid got %0h exp 0", bus.wb_valid); end
    checks++; if (bus.fu_operation !== `FPU_ADD) begin errors++; $display("FAIL rmw_operation got %0h exp %0h", bus.fu_operation, `FPU_ADD); end
    @(negedge clk);
    reset = 1'b0;
    bus.fu_ready  = 1'b1;
    bus.fu_result = 32'h0000_0800;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL rmw_post_wb_valid_%0d got %0h exp 0", c, bus.wb_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rmw_post_busy_%0d got %0h exp 0", c, bus.busy); end
    end
  endtask

  task automatic test_timeout();
    int c;
    int bad;
    bus.fu_ready = 1'b0;
    bus.wb_ready = 1'b1;
    issue(`FPU_MUL, 32'h0000_0800, 32'h0000_0800, 5'd6);
`ifdef FPU_TIMEOUT_EN
    c = 0;
    while (bus.wb_valid !== 1'b1 && c < 200) begin
      tick();
      c++;
      bus.req_valid = 1'b0;
    end
    checks++; if (c != 66) begin errors++; $display("FAIL to_cycle got %0d exp 66", c); end
    checks++; if (bus.wb_err !== 1'b1) begin errors++; $display("FAIL to_wb_err got %0h exp 1", bus.wb_err); end
    checks++; if (bus.wb_data !== 32'h0) begin errors++; $display("FAIL to_wb_data got %h exp 0", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd6) begin errors++; $display("FAIL to_wb_rd got %0d exp 6", bus.wb_rd); end
    tick();
`else
    bad = 0;
    for (c = 1; c <= 200; c++) begin
      tick();
      bus.req_valid = 1'b0;
      if (bus.wb_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL nto_wb_valid_cycles got %0d exp 0", bad); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL nto_busy got %0h exp 1", bus.busy); end
    bus.fu_ready  = 1'b1;
    bus.fu_result = 32'h0000_1000;
    tick();
    bus.fu_ready = 1'b0;
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL nto_late_wb_valid got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'h0000_1000) begin errors++; $display("FAIL nto_late_wb_data got %h exp 00001000", bus.wb_data); end
    checks++; if (bus.wb_err !== 1'b0) begin errors++; $display("FAIL nto_late_wb_err got %0h exp 0", bus.wb_err); end
    tick();
`endif
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL to_after_wb_valid got %0h exp 0", bus.wb_valid); end
  endtask

  task automatic test_back_to_back();
    bus.fu_ready  = 1'b1;
    bus.fu_result = 32'h0000_0600;
    bus.wb_ready  = 1'b1;
    issue(`FPU_ADD, 32'h0000_0400, 32'h0000_0200, 5'd1);
    tick();  // cycle 1: next request already waiting
    issue(`FPU_SQRT, 32'h0000_1000, 32'h0, 5'd8);
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_req_ready_c1 got %0h exp 0", bus.req_ready); end
    tick();  // cycle 2: first writeback handshake
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid_c2 got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'h0000_0600) begin errors++; $display("FAIL b2b_wb_data_c2 got %h exp 00000600", bus.wb_data); end
    tick();  // cycle 3: IDLE, SQRT accepted here
    bus.fu_result = 32'h0000_0800;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_req_ready_c3 got %0h exp 1", bus.req_ready); end
    tick();  // cycle 4: ISSUE
    bus.req_valid = 1'b0;
    checks++; if (bus.fu_operation !== `FPU_SQRT) begin errors++; $display("FAIL b2b_operation_c4 got %0h exp %0h", bus.fu_operation, `FPU_SQRT); end
    checks++; if (bus.fu_operand_1 !== 32'h0000_1000) begin errors++; $display("FAIL b2b_op1_c4 got %h exp 00001000", bus.fu_operand_1); end
    for (int c = 5; c <= 7; c++) begin
      tick();
      checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_wb_valid_c%0d got %0h exp 0", c, bus.wb_valid); end
    end
    tick();  // cycle 8
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid_c8 got %0h exp 1", bus.wb_valid); end
    checks++; if (bus.wb_data !== 32'h0000_0800) begin errors++; $display("FAIL b2b_wb_data_c8 got %h exp 00000800", bus.wb_data); end
    checks++; if (bus.wb_rd !== 5'd8) begin errors++; $display("FAIL b2b_wb_rd_c8 got %0d exp 8", bus.wb_rd); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_wb_valid_c9 got %0h exp 0", bus.wb_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op    = `FPU_ADD;
    bus.req_op1   = '0;
    bus.req_op2   = '0;
    bus.req_rd    = '0;
    bus.fu_result = '0;
    bus.fu_ready  = 1'b0;
    bus.wb_ready  = 1'b0;
    test_reset();
    test_add();
    test_mul_stale();
    test_min_wait_edge();
    test_backpressure();
    test_reset_mid_wait();
    test_timeout();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
